// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared reset PC default and fetch FSM encodings for the fetch stage
package ifu_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  typedef enum logic [1:0] {IF_IDLE = 2'd0, IF_REQ = 2'd1, IF_WAIT = 2'd2} if_state_t;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: decode-side handshake/redirect signals and inst-SRAM bus; master = fetch stage, slave = decode+SRAM
interface ifu_fetch_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_stall;
  logic        i_id_ready;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  modport master (
    input  br_taken, br_target, br_stall, i_id_ready,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output if_to_id_valid, if_to_id_pc, if_to_id_inst, inst_sram_req, inst_sram_addr
  );
  modport slave (
    output br_taken, br_target, br_stall, i_id_ready,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_pc, if_to_id_inst, inst_sram_req, inst_sram_addr
  );
endinterface

// File: rtl/ifu_fetch_out_buf.sv
// ifu_fetch_out_buf: 1-entry pc/inst buffer toward decode; ports load/flush/pop in, valid/pc/inst out (flush wins)
module ifu_fetch_out_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        pop,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : valid;
      if (load && !flush) begin
        pc   <= pc_in;
        inst <= inst_in;
      end
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch stage; clk/rst plus bus (redirect/stall/ready from decode, inst-SRAM req/addr/ok/rdata, buffered pc/inst to decode)
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  if_state_t   state, state_nx;
  logic [31:0] fetch_pc, req_pc;
  logic        discard, cancel;
  logic        xfer, slot_free, accept, resp, load;
  assign xfer      = bus.if_to_id_valid & bus.i_id_ready;
  assign slot_free = !bus.if_to_id_valid | xfer;
  assign accept    = (state == IF_REQ) & bus.inst_sram_addr_ok;
  assign resp      = (state == IF_WAIT) & bus.inst_sram_data_ok;
  assign load      = resp & !discard & !bus.br_taken;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IF_IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = state == IF_IDLE ? ((slot_free && !bus.br_stall && !bus.br_taken) ? IF_REQ : IF_IDLE)
             : state == IF_REQ  ? (accept ? IF_WAIT : IF_REQ)
             : state == IF_WAIT ? (resp ? IF_IDLE : IF_WAIT)
             : IF_IDLE;
  always_comb begin
    bus.inst_sram_req  = state == IF_REQ;
    bus.inst_sram_addr = state == IF_REQ ? req_pc : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      discard  <= 1'b0;
      cancel   <= 1'b0;
    end else begin
      // req_pc is latched when the request is issued so the address stays put even if fetch_pc is redirected
      if (state == IF_IDLE && state_nx == IF_REQ) req_pc <= fetch_pc;
      if (bus.br_taken) fetch_pc <= bus.br_target;
      else if (accept && !cancel) fetch_pc <= req_pc + 32'd4;
      cancel  <= (state == IF_REQ) & !accept & (cancel | bus.br_taken);
      discard <= accept ? (cancel | bus.br_taken)
               : resp   ? 1'b0
               : discard | ((state == IF_WAIT) & bus.br_taken);
    end
  ifu_fetch_out_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .flush  (bus.br_taken),
    .pop    (xfer),
    .pc_in  (req_pc),
    .inst_in(bus.inst_sram_rdata),
    .valid  (bus.if_to_id_valid),
    .pc     (bus.if_to_id_pc),
    .inst   (bus.if_to_id_inst)
  );
endmodule
